// File: rtl/addr_decoding_prog_pkg.sv
// addr_decoding_prog_pkg: shared memory-map constants for the address decoders and the program ROM
package addr_decoding_prog_pkg;
    localparam logic [31:0] PROG_BASE  = 32'h0000_0240;
    localparam logic [31:0] PROG_LIMIT = 32'h0000_123F;
    localparam logic [31:0] PROG_SIZE  = PROG_LIMIT - PROG_BASE + 32'd1;
endpackage

// File: rtl/addr_range_cmp.sv
// addr_range_cmp: inclusive unsigned window compare with window-relative offset
module addr_range_cmp #(
    parameter logic [31:0] BASE  = 32'h0,
    parameter logic [31:0] LIMIT = 32'hFFFF_FFFF
) (
    input  logic [31:0] addr,
    output logic        hit,
    output logic [31:0] offset
);
    // offset is forced to zero on a miss so downstream never sees a stale or wrapped value
    always_comb begin
        hit    = (addr >= BASE) && (addr <= LIMIT);
        offset = hit ? addr - BASE : 32'h0;
    end
endmodule

// File: rtl/addr_decoding_prog.sv
// addr_decoding_prog: registered program-ROM chip select and window-relative fetch address
module addr_decoding_prog
    import addr_decoding_prog_pkg::*;
#(
    parameter logic [31:0] PROG_BASE  = addr_decoding_prog_pkg::PROG_BASE,
    parameter logic [31:0] PROG_LIMIT = addr_decoding_prog_pkg::PROG_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    output logic        CS_P,
    output logic [31:0] iAddressInst
);
    logic        hit;
    logic [31:0] offset;
    logic        cs_p_d, cs_p_q;
    logic [31:0] i_address_inst_d, i_address_inst_q;

    addr_range_cmp #(.BASE(PROG_BASE), .LIMIT(PROG_LIMIT)) u_cmp (
        .addr  (addr),
        .hit   (hit),
        .offset(offset)
    );

    // next output values straight from the range compare
    always_comb begin
        cs_p_d           = hit;
        i_address_inst_d = offset;
    end

    // output register; reset wins over the decode on the same edge
    always_ff @(posedge clk) begin
        cs_p_q           <= rst ? 1'b0 : cs_p_d;
        i_address_inst_q <= rst ? 32'h0 : i_address_inst_d;
    end

    assign CS_P         = cs_p_q;
    assign iAddressInst = i_address_inst_q;
endmodule

// File: tb/tb_addr_decoding_prog.sv
// tb_addr_decoding_prog: directed and random checks of the program-window decoder
module tb_addr_decoding_prog;
    localparam longint BASE  = 64'h240;
    localparam longint LIMIT = 64'h123F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        CS_P;
    logic [31:0] iAddressInst;
    int          n_asserts = 0;
    int          n_fails = 0;

    addr_decoding_prog dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .CS_P        (CS_P),
        .iAddressInst(iAddressInst)
    );

    always #5 clk = ~clk;

    // drive one address for one edge, then compare with the window rule
    task automatic step(input string tag, input logic [31:0] a, input logic r);
        logic        exp_cs;
        logic [31:0] exp_off;
        longint      la;
        @(negedge clk);
        addr = a;
        rst  = r;
        la   = longint'(a);
        exp_cs  = !r && la >= BASE && la <= LIMIT;
        exp_off = exp_cs ? 32'(la - BASE) : 32'h0;
        @(posedge clk);
        #1;
        n_asserts++;
        assert (CS_P === exp_cs) else begin
            n_fails++;
            $error("FAIL %s cs_p addr=%h observed=%0b expected=%0b", tag, a, CS_P, exp_cs);
        end
        n_asserts++;
        assert (iAddressInst === exp_off) else begin
            n_fails++;
            $error("FAIL %s offset addr=%h observed=%h expected=%h", tag, a, iAddressInst, exp_off);
        end
    endtask

    initial begin
        logic [31:0] a;
        step("reset0", 32'h240, 1'b1);
        step("reset1", 32'h240, 1'b1);
        step("release", 32'h240, 1'b0);
        step("below", 32'h230, 1'b0);
        step("lower_m1", 32'h23F, 1'b0);
        step("lower", 32'h240, 1'b0);
        step("upper", 32'h123F, 1'b0);
        step("upper_p1", 32'h1240, 1'b0);
        step("above", 32'h2F0F, 1'b0);
        step("max", 32'hFFFF_FFFF, 1'b0);
        step("zero", 32'h0, 1'b0);
        step("b2b0", 32'h240, 1'b0);
        step("b2b1", 32'h800, 1'b0);
        step("b2b2", 32'h2F0F, 1'b0);
        step("b2b3", 32'h123F, 1'b0);
        step("mid0", 32'h240, 1'b0);
        step("mid_rst", 32'h800, 1'b1);
        step("mid2", 32'h2F0F, 1'b0);
        step("mid3", 32'h123F, 1'b0);
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(3))
                0: a = 32'h23C + $urandom_range(8);
                1: a = 32'h123C + $urandom_range(8);
                2: a = 32'h240 + $urandom_range(32'hFFF);
                default: a = $urandom;
            endcase
            step("random", a, $urandom_range(19) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
